// File: rtl/univ_shift_reg_burst_if.sv
// Bus bundle for univ_shift_reg_burst: parallel/serial data, mode select,
// burst request and the register/handshake outputs.
//  master : drives p, dsr, dsl, s, start, count; observes q, sout_l, sout_r, busy, done
//  slave  : the shift register itself
interface univ_shift_reg_burst_if #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned CNTW   = 4
);
  logic [LENGTH-1:0] p;
  logic              dsr;
  logic              dsl;
  logic [2:0]        s;
  logic              start;
  logic [CNTW-1:0]   count;
  logic [LENGTH-1:0] q;
  logic              sout_l;
  logic              sout_r;
  logic              busy;
  logic              done;

  modport master (
    output p, dsr, dsl, s, start, count,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  p, dsr, dsl, s, start, count,
    output q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_burst.sv
// Universal shift register (hold/shift/load/rotate/arith-right/clear) with a
// burst engine that repeats one shift/rotate mode COUNT times.
//  CLOCK : rising-edge clock
//  _MR   : asynchronous active-low master reset
//  bus   : slave side of univ_shift_reg_burst_if (p, dsr, dsl, s, start, count in;
//          q, busy, done registered out; sout_l/sout_r are taps of q)
module univ_shift_reg_burst #(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned CNTW   = 4
) (
  input logic                    CLOCK,
  input logic                    _MR,
  univ_shift_reg_burst_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] M_HOLD  = 3'd0;
  localparam logic [2:0] M_SHL   = 3'd1;
  localparam logic [2:0] M_SHR   = 3'd2;
  localparam logic [2:0] M_LOAD  = 3'd3;
  localparam logic [2:0] M_ROL   = 3'd4;
  localparam logic [2:0] M_ROR   = 3'd5;
  localparam logic [2:0] M_ASR   = 3'd6;
  localparam logic [2:0] M_CLEAR = 3'd7;

  logic [0:0]        state_r, state_n;
  logic [LENGTH-1:0] q_r, q_n;
  logic [CNTW-1:0]   cnt_r, cnt_n;
  logic [2:0]        mode_r, mode_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;

  // One step of mode m applied to v.
  function automatic logic [LENGTH-1:0] step_fn(
    input logic [2:0]        m,
    input logic [LENGTH-1:0] v,
    input logic [LENGTH-1:0] ld,
    input logic              sr,
    input logic              sl
  );
    logic [LENGTH-1:0] r;
    r = v;
    case (m)
      M_HOLD:  r = v;
      M_SHL:   r = {v[LENGTH-2:0], sr};
      M_SHR:   r = {sl, v[LENGTH-1:1]};
      M_LOAD:  r = ld;
      M_ROL:   r = {v[LENGTH-2:0], v[LENGTH-1]};
      M_ROR:   r = {v[0], v[LENGTH-1:1]};
      M_ASR:   r = {v[LENGTH-1], v[LENGTH-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only the shift/rotate modes can be repeated as a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) ||
           (m == M_ROR) || (m == M_ASR);
  endfunction

  // State and datapath registers.
  always_ff @(posedge CLOCK or negedge _MR) begin
    if (!_MR) begin
      state_r <= IDLE;
      q_r     <= '0;
      cnt_r   <= '0;
      mode_r  <= M_HOLD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      q_r     <= q_n;
      cnt_r   <= cnt_n;
      mode_r  <= mode_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  // Next-state and next-output logic.
  // START with a non-burst mode (hold/load/clear) is ignored entirely,
  // so it never produces a DONE even when COUNT is zero.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    cnt_n   = cnt_r;
    mode_n  = mode_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && is_burst_mode(bus.s)) begin
          if (bus.count == '0) begin
            done_n = 1'b1;
          end else begin
            mode_n  = bus.s;
            cnt_n   = bus.count;
            state_n = RUN;
          end
        end else begin
          q_n = step_fn(bus.s, q_r, bus.p, bus.dsr, bus.dsl);
        end
      end
      RUN: begin
        q_n   = step_fn(mode_r, q_r, bus.p, bus.dsr, bus.dsl);
        cnt_n = cnt_r - CNTW'(1);
        if (cnt_r == CNTW'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
  end

  assign bus.q      = q_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.sout_l = q_r[LENGTH-1];
  assign bus.sout_r = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Self-checking bench for univ_shift_reg_burst: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a remaining-steps behavioural model.
module tb_univ_shift_reg_burst;
  localparam int unsigned L  = 8;
  localparam int unsigned CW = 4;

  logic CLOCK = 1'b0;
  logic _MR;
  always #5 CLOCK = ~CLOCK;

  univ_shift_reg_burst_if #(.LENGTH(L), .CNTW(CW)) bus ();
  univ_shift_reg_burst #(.LENGTH(L), .CNTW(CW)) dut (.CLOCK(CLOCK), ._MR(_MR), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: Q as an integer value, burst as "steps remaining".
  logic [L-1:0] m_q;
  int           m_left;
  logic [2:0]   m_mode;
  logic         m_done;

  function automatic logic [L-1:0] mstep(input logic [2:0] m, input logic [L-1:0] v,
                                         input logic [L-1:0] ld, input logic sr, input logic sl);
    logic [L-1:0] r;
    case (m)
      3'd1:    r = (v << 1) | L'(sr);
      3'd2:    r = (v >> 1) | (L'(sl) << (L - 1));
      3'd3:    r = ld;
      3'd4:    r = (v << 1) | (v >> (L - 1));
      3'd5:    r = (v >> 1) | (v << (L - 1));
      3'd6:    r = L'($signed(v) >>> 1);
      3'd7:    r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  always @(posedge CLOCK or negedge _MR) begin
    if (!_MR) begin
      m_q <= '0; m_left <= 0; m_mode <= 3'd0; m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_q    <= mstep(m_mode, m_q, bus.p, bus.dsr, bus.dsl);
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
    end else if (bus.start && (bus.s inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
      m_done <= (bus.count == '0);
      m_left <= int'(bus.count);
      m_mode <= bus.s;
    end else begin
      m_q    <= mstep(bus.s, m_q, bus.p, bus.dsr, bus.dsl);
      m_done <= 1'b0;
    end
  end

  // Continuous comparison on the falling edge, while out of reset.
  always @(negedge CLOCK) begin
    if (_MR === 1'b1) begin
      chk("q",      32'(bus.q),      32'(m_q));
      chk("busy",   32'(bus.busy),   32'(m_left > 0));
      chk("done",   32'(bus.done),   32'(m_done));
      chk("sout_l", 32'(bus.sout_l), 32'(m_q[L-1]));
      chk("sout_r", 32'(bus.sout_r), 32'(m_q[0]));
      chk("done_busy_excl", 32'(bus.done & bus.busy), 32'(0));
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic drive(input logic [2:0] s, input logic start, input logic [CW-1:0] count,
                       input logic [L-1:0] p, input logic dsr, input logic dsl);
    bus.s = s; bus.start = start; bus.count = count; bus.p = p; bus.dsr = dsr; bus.dsl = dsl;
  endtask

  logic [2:0]    rs;
  logic [CW-1:0] rc;

  initial begin
    _MR = 1'b0;
    drive(3'd0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    _MR = 1'b1;

    // Legacy modes
    drive(3'd3, 1'b0, '0, 8'hA5, 1'b0, 1'b0); tick(); chk("load_a5", 32'(bus.q), 32'hA5);
    drive(3'd1, 1'b0, '0, 8'h00, 1'b1, 1'b0); tick(); chk("shl_4b", 32'(bus.q), 32'h4B);
    drive(3'd2, 1'b0, '0, 8'h00, 1'b0, 1'b0); tick(); chk("shr_25", 32'(bus.q), 32'h25);
    drive(3'd0, 1'b0, '0, 8'hFF, 1'b1, 1'b1); tick(); tick(); chk("hold_25", 32'(bus.q), 32'h25);
    drive(3'd7, 1'b0, '0, 8'hFF, 1'b1, 1'b1); tick(); chk("clear_00", 32'(bus.q), 32'h00);

    // Asynchronous reset mid-cycle
    drive(3'd3, 1'b0, '0, 8'hA5, 1'b0, 1'b0); tick();
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    #1 _MR = 1'b0;
    #1 chk("async_rst_q", 32'(bus.q), 32'h00);
    chk("async_rst_busy", 32'(bus.busy), 32'(0));
    chk("async_rst_done", 32'(bus.done), 32'(0));
    tick(); _MR = 1'b1;

    // Burst rotate left x3 from 0x81
    drive(3'd3, 1'b0, '0, 8'h81, 1'b0, 1'b0); tick();
    drive(3'd4, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0); tick();
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("rol_busy1", 32'(bus.busy), 32'(1)); tick();
    chk("rol_busy2", 32'(bus.busy), 32'(1)); tick();
    chk("rol_busy3", 32'(bus.busy), 32'(1)); tick();
    chk("rol_q", 32'(bus.q), 32'h0C);
    chk("rol_done", 32'(bus.done), 32'(1));
    chk("rol_busy_end", 32'(bus.busy), 32'(0)); tick();
    chk("rol_done_pulse", 32'(bus.done), 32'(0));

    // Burst arith right x10 from 0x90, with S/P/START noise during the run
    drive(3'd3, 1'b0, '0, 8'h90, 1'b0, 1'b0); tick();
    drive(3'd6, 1'b1, 4'd10, 8'h00, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom), 1'($urandom), CW'($urandom), L'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    chk("asr_q", 32'(bus.q), 32'hFF);
    chk("asr_done", 32'(bus.done), 32'(1));
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0); tick();

    // START with COUNT=0
    drive(3'd3, 1'b0, '0, 8'h3C, 1'b0, 1'b0); tick();
    drive(3'd1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1); tick();
    chk("cnt0_q", 32'(bus.q), 32'h3C);
    chk("cnt0_done", 32'(bus.done), 32'(1));
    chk("cnt0_busy", 32'(bus.busy), 32'(0));
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0); tick();
    chk("cnt0_done_pulse", 32'(bus.done), 32'(0));

    // START with S=3 is a plain load
    drive(3'd3, 1'b1, 4'd5, 8'h5A, 1'b0, 1'b0); tick();
    chk("start_load_q", 32'(bus.q), 32'h5A);
    chk("start_load_busy", 32'(bus.busy), 32'(0));
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0); tick();

    // Abort at step 2 of a COUNT=5 burst
    drive(3'd3, 1'b0, '0, 8'h0F, 1'b0, 1'b0); tick();
    drive(3'd1, 1'b1, 4'd5, 8'h00, 1'b1, 1'b0); tick();
    drive(3'd0, 1'b0, '0, 8'h00, 1'b1, 1'b0); tick(); tick();
    chk("abort_pre_busy", 32'(bus.busy), 32'(1));
    #1 _MR = 1'b0;
    #1 chk("abort_q", 32'(bus.q), 32'h00);
    chk("abort_busy", 32'(bus.busy), 32'(0));
    tick(); _MR = 1'b1; tick();
    chk("abort_no_done", 32'(bus.done), 32'(0));

    // Back-to-back bursts
    drive(3'd3, 1'b0, '0, 8'h01, 1'b0, 1'b0); tick();
    drive(3'd5, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0); tick();
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0); tick(); tick();
    chk("b2b_done1", 32'(bus.done), 32'(1));
    chk("b2b_q1", 32'(bus.q), 32'h40);
    drive(3'd2, 1'b1, 4'd1, 8'h00, 1'b0, 1'b1); tick();
    chk("b2b_busy2", 32'(bus.busy), 32'(1));
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b1); tick();
    chk("b2b_done2", 32'(bus.done), 32'(1));
    chk("b2b_q2", 32'(bus.q), 32'hA0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      rs = 3'($urandom);
      rc = CW'($urandom);
      if (!(rs inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && rc == '0) rc = CW'(1);
      drive(rs, ($urandom_range(0, 2) == 0), rc, L'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(3'd0, 1'b0, '0, 8'h00, 1'b0, 1'b0);
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
